// File: rtl/vfx_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vfx_stream_pkg : shared types for the RGB444 pixel stream blocks      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vfx_stream_pkg;

  localparam int PIXEL_W   = 12;
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [3:0]         nibble_t;

  function automatic nibble_t pix_r(input pixel_t p);
    return p[11:8];
  endfunction

  function automatic nibble_t pix_g(input pixel_t p);
    return p[7:4];
  endfunction

  function automatic nibble_t pix_b(input pixel_t p);
    return p[3:0];
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_skid_fifo : 2-entry FIFO of {sop, eop, pixel} output beats     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module stream_skid_fifo
  import vfx_stream_pkg::*;
#(
  parameter int W = PIXEL_W + 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/video_stream_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_stream_source : frame RAM reader emitting one Avalon-ST packet  |
// | per frame with ready back-pressure and 1 pixel/cycle throughput       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module video_stream_source
  import vfx_stream_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = PIXEL_W,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ready_in,
  output logic              valid_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam int                FIFO_W    = DATA_W + 2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                inflight_q, inflight_d;
  logic                sop_dly_q, sop_dly_d;
  logic                eop_dly_q, eop_dly_d;
  logic                frame_done_q, frame_done_d;

  logic [FIFO_W-1:0]   head;
  logic [1:0]          count;
  logic                fifo_nonempty;
  logic                pop;
  logic [2:0]          occ_after;
  logic                head_sop, head_eop;
  logic [DATA_W-1:0]   head_pix;

  assign {head_sop, head_eop, head_pix} = head;
  assign fifo_nonempty = (count != 2'd0);
  assign pop           = fifo_nonempty && ready_in;

  stream_skid_fifo #(
    .W(FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (inflight_q),
    .push_data({sop_dly_q, eop_dly_q, rd_data}),
    .pop      (pop),
    .head_data(head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      sop_dly_q    <= 1'b0;
      eop_dly_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      sop_dly_q    <= sop_dly_d;
      eop_dly_q    <= eop_dly_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Packet flags ride alongside the read so they land in the FIFO with rd_data.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    inflight_d   = rd_en;
    sop_dly_d    = (addr_q == '0);
    eop_dly_d    = (addr_q == LAST_ADDR);
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = STREAM;
          addr_d  = '0;
        end
      end
      STREAM: begin
        if (rd_en) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && head_eop) begin
          frame_done_d = 1'b1;
          state_d      = enable ? STREAM : IDLE;
          addr_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit: entries held plus the read in flight, less this cycle's pop, must leave room.
  always_comb begin
    occ_after         = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en             = (state_q == STREAM) && (occ_after < 3'd2);
    rd_addr           = rd_en ? addr_q : '0;
    valid_out         = fifo_nonempty;
    startofpacket_out = fifo_nonempty && head_sop;
    endofpacket_out   = fifo_nonempty && head_eop;
    data_out          = fifo_nonempty ? head_pix : '0;
    busy              = (state_q != IDLE);
    frame_done        = frame_done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_video_stream_source.sv
`default_nettype none
// Directed + randomized bench for video_stream_source on a 4x2 frame whose
// RAM returns data equal to the address.
module tb_video_stream_source;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 17;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b1;
  logic              enable   = 1'b0;
  logic              ready_in = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data  = '0;
  logic              valid_out, sop, eop, busy, frame_done;
  logic [DATA_W-1:0] data_out;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int   exp_idx, exp_rd, outstanding, beats, done_count;
  bit   hold_pending, done_due, prev_valid;
  logic [DATA_W-1:0] hold_data;
  logic hold_sop, hold_eop;
  int   rise_cycs[$];
  int   eop_cycs[$];
  int   done_cycs[$];
  int   rd_cycs[$];

  video_stream_source #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .ready_in         (ready_in),
    .valid_out        (valid_out),
    .startofpacket_out(sop),
    .endofpacket_out  (eop),
    .data_out         (data_out),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= DATA_W'(rd_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_idx = 0; exp_rd = 0; outstanding = 0; beats = 0;
    hold_pending = 0; done_due = 0; prev_valid = 0;
    rise_cycs.delete(); eop_cycs.delete(); done_cycs.delete(); rd_cycs.delete();
  endtask

  task automatic clear_records();
    beats = 0;
    rise_cycs.delete(); eop_cycs.delete(); done_cycs.delete(); rd_cycs.delete();
  endtask

  // One clock: sample at the falling edge, compare against the model, advance.
  task automatic run_cycle();
    bit xfer;
    @(negedge clk);
    chk("frame_done", frame_done, done_due);
    if (hold_pending) begin
      chk("hold_valid", valid_out, 1);
      chk("hold_data", data_out, hold_data);
      chk("hold_sop", sop, hold_sop);
      chk("hold_eop", eop, hold_eop);
    end
    xfer = valid_out && ready_in;
    if (rd_en) begin
      chk("rd_addr", rd_addr, exp_rd);
      exp_rd = (exp_rd + 1) % NPIX;
      outstanding++;
      rd_cycs.push_back(cyc);
    end
    if (valid_out && !prev_valid) rise_cycs.push_back(cyc);
    if (xfer) begin
      chk("beat_data", data_out, exp_idx);
      chk("beat_sop", sop, exp_idx == 0);
      chk("beat_eop", eop, exp_idx == NPIX - 1);
      if (eop) eop_cycs.push_back(cyc);
      exp_idx = (exp_idx + 1) % NPIX;
      outstanding--;
      beats++;
    end
    chk("outstanding_le2", outstanding <= 2, 1);
    if (frame_done) begin
      done_count++;
      done_cycs.push_back(cyc);
    end
    done_due     = xfer && eop;
    hold_pending = valid_out && !ready_in;
    hold_data    = data_out;
    hold_sop     = sop;
    hold_eop     = eop;
    prev_valid   = valid_out;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input int nframes, input int budget, input bit rand_ready);
    int target;
    int k;
    target = done_count + nframes;
    k = 0;
    while (done_count < target && k < budget) begin
      if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
      run_cycle();
      k++;
    end
    chk("frames_done", done_count, target);
  endtask

  initial begin
    int n;
    int k;
    done_count = 0;
    model_reset();

    // 1: reset state and idle with enable low
    #2 reset_n = 1'b0;
    #10;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sop", sop, 0);
    chk("rst_eop", eop, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (20) begin
      run_cycle();
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid_out, 0);
    end
    chk("idle_no_reads", rd_cycs.size(), 0);

    // 2: single-frame latency with ready high
    clear_records();
    ready_in = 1'b1;
    enable = 1'b1;
    n = cyc + 1;
    run_cycle();
    enable = 1'b0;
    run_frames(1, 40, 0);
    chk("s2_beats", beats, NPIX);
    chk("s2_first_rd", (rd_cycs.size() > 0) ? rd_cycs[0] : -1, n);
    chk("s2_first_valid", (rise_cycs.size() > 0) ? rise_cycs[0] : -1, n + 2);
    chk("s2_eop_cycle", (eop_cycs.size() > 0) ? eop_cycs[0] : -1, n + 2 + NPIX - 1);
    chk("s2_done_cycle", (done_cycs.size() > 0) ? done_cycs[0] : -1, n + 2 + NPIX);
    run_cycle();
    chk("s2_idle_busy", busy, 0);

    // 3: alternating ready
    clear_records();
    enable = 1'b1;
    ready_in = 1'b1;
    run_cycle();
    enable = 1'b0;
    k = 0;
    while (done_count < 2 && k < 60) begin
      ready_in = (k % 2 == 0);
      run_cycle();
      k++;
    end
    chk("s3_frames", done_count, 2);
    chk("s3_beats", beats, NPIX);
    ready_in = 1'b1;
    run_cycle();
    chk("s3_idle_busy", busy, 0);

    // 4: stall on the first beat
    clear_records();
    ready_in = 1'b0;
    enable = 1'b1;
    run_cycle();
    enable = 1'b0;
    k = 0;
    while (!prev_valid && k < 10) begin
      run_cycle();
      k++;
    end
    repeat (20) run_cycle();
    chk("s4_stall_valid", valid_out, 1);
    chk("s4_stall_data", data_out, 0);
    chk("s4_stall_sop", sop, 1);
    chk("s4_stall_reads", rd_cycs.size(), 2);
    ready_in = 1'b1;
    run_frames(1, 40, 0);
    chk("s4_beats", beats, NPIX);

    // 5: back-to-back frames, enable dropped during the second
    clear_records();
    ready_in = 1'b1;
    enable = 1'b1;
    run_frames(1, 40, 0);
    enable = 1'b0;
    run_frames(1, 40, 0);
    chk("s5_beats", beats, 2 * NPIX);
    chk("s5_gap", (rise_cycs.size() > 1 && eop_cycs.size() > 0) ? rise_cycs[1] - eop_cycs[0] : -1, 3);
    chk("s5_done_count", done_cycs.size(), 2);
    repeat (3) run_cycle();
    chk("s5_idle_busy", busy, 0);
    chk("s5_no_extra_beats", beats, 2 * NPIX);

    // 7: random back-pressure over two frames
    clear_records();
    enable = 1'b1;
    run_frames(1, 200, 1);
    enable = 1'b0;
    run_frames(1, 200, 1);
    chk("s7_beats", beats, 2 * NPIX);
    ready_in = 1'b1;
    repeat (3) run_cycle();
    chk("s7_idle_busy", busy, 0);

    // 6: reset while beat 3 is presented
    clear_records();
    ready_in = 1'b1;
    enable = 1'b1;
    k = 0;
    while (beats < 3 && k < 20) begin
      run_cycle();
      k++;
    end
    @(negedge clk);
    chk("s6_pre_valid", valid_out, 1);
    chk("s6_pre_data", data_out, 3);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_valid", valid_out, 0);
    chk("s6_rst_data", data_out, 0);
    chk("s6_rst_sop", sop, 0);
    chk("s6_rst_rd_en", rd_en, 0);
    chk("s6_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) run_cycle();
    enable = 1'b0;
    run_frames(1, 40, 0);
    chk("s6_beats", beats, NPIX);
    chk("s6_restart_rise", rise_cycs.size(), 1);
    run_cycle();
    chk("s6_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
